bias_add_stream: RTL and testbench

- Parametrised successor to the fixed per-layer bias ROMs.
- Bias values are loaded at run time over a streaming port into an internal register file of NUM_CH entries. One instance then serves any conv/expand layer.
- In RUN it adds the per-channel bias to a channel-serial accumulator stream, with optional ReLU and signed saturation to OUT_W.
- Sits between the MAC accumulator output and the activation buffer of each fire/conv stage.

---
 rtl/bias_add_stream_if.sv | 42 ++++
 rtl/bias_add_stream.sv | 142 ++++++++++++++
 tb/tb_bias_add_stream.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bias_add_stream_if.sv
// Streaming interface of bias_add_stream. It groups the bias-load port, the
// accumulator input stream, the biased output stream and the status flags.
//   slave  : the bias_add_stream block
//   master : the environment (bias loader, MAC accumulator, activation buffer)
// Signals:
//   bias_load_start, bias_in_valid, bias_in, bias_in_ready, bias_loaded
//   relu_en, acc_valid, acc_in, acc_ready
//   out_valid, out_data, out_last, out_ready, sat_flag
interface bias_add_stream_if #(
  parameter int ACC_W  = 32,
  parameter int BIAS_W = 32,
  parameter int OUT_W  = 16
);
  logic                     bias_load_start;
  logic                     bias_in_valid;
  logic signed [BIAS_W-1:0] bias_in;
  logic                     bias_in_ready;
  logic                     bias_loaded;
  logic                     relu_en;
  logic                     acc_valid;
  logic signed [ACC_W-1:0]  acc_in;
  logic                     acc_ready;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_last;
  logic                     out_ready;
  logic                     sat_flag;

  modport slave (
    input  bias_load_start, bias_in_valid, bias_in, relu_en,
           acc_valid, acc_in, out_ready,
    output bias_in_ready, bias_loaded, acc_ready,
           out_valid, out_data, out_last, sat_flag
  );

  modport master (
    output bias_load_start, bias_in_valid, bias_in, relu_en,
           acc_valid, acc_in, out_ready,
    input  bias_in_ready, bias_loaded, acc_ready,
           out_valid, out_data, out_last, sat_flag
  );
endinterface

// File: rtl/bias_add_stream.sv
// bias_add_stream: per-channel bias add with optional ReLU and signed
// saturation, for a channel-serial accumulator stream. Biases are loaded at
// run time into an NUM_CH-entry register file; the block then serves any layer.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - bias_add_stream_if.slave (bias load, acc stream, output stream, flags)
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | no biases held, streams idle
// S_LOAD | accepting bias words into entry[widx], widx = 0..NUM_CH-1
// S_RUN  | biases held; acc beats biased, activated and saturated
module bias_add_stream #(
  parameter int NUM_CH = 64,
  parameter int ACC_W  = 32,
  parameter int BIAS_W = 32,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  bias_add_stream_if.slave  bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  // Output limits expressed at the ACC_W+1 sum width.
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t                   r_state, w_state_nxt;
  logic signed [BIAS_W-1:0] r_bias [NUM_CH];
  logic [CH_W-1:0]          r_widx;
  logic [CH_W-1:0]          r_ch;
  logic                     r_bias_loaded;
  logic                     r_out_valid;
  logic signed [OUT_W-1:0]  r_out_data;
  logic                     r_out_last;
  logic                     r_sat_flag;

  logic                     w_bias_wr;
  logic                     w_bias_last;
  logic                     w_acc_ready;
  logic                     w_acc_take;
  logic signed [ACC_W:0]    w_acc_ext;
  logic signed [ACC_W:0]    w_bias_ext;
  logic signed [ACC_W:0]    w_sum;
  logic signed [ACC_W:0]    w_act;
  logic signed [ACC_W:0]    w_res;
  logic                     w_sat;

  // A load start wins over everything in its cycle, so neither a bias word
  // nor an acc beat is taken while it is asserted.
  assign w_bias_wr   = (r_state == S_LOAD) && bus.bias_in_valid && !bus.bias_load_start;
  assign w_bias_last = w_bias_wr && (r_widx == LAST_CH);
  assign w_acc_ready = (r_state == S_RUN) && !bus.bias_load_start &&
                       (!r_out_valid || bus.out_ready);
  assign w_acc_take  = bus.acc_valid && w_acc_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.bias_load_start) begin
      w_state_nxt = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD:  if (w_bias_last) w_state_nxt = S_RUN;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Datapath: sum at ACC_W+1 bits cannot overflow, then ReLU, then clamp.
  always_comb begin
    w_acc_ext  = {bus.acc_in[ACC_W-1], bus.acc_in};
    w_bias_ext = {{(ACC_W+1-BIAS_W){r_bias[r_ch][BIAS_W-1]}}, r_bias[r_ch]};
    w_sum      = w_acc_ext + w_bias_ext;
    w_act      = (bus.relu_en && (w_sum < 0)) ? '0 : w_sum;
    w_sat      = 1'b0;
    w_res      = w_act;
    if (w_act > SAT_MAX) begin
      w_res = SAT_MAX;
      w_sat = 1'b1;
    end else if (w_act < SAT_MIN) begin
      w_res = SAT_MIN;
      w_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) r_bias[i] <= '0;
      r_widx        <= '0;
      r_ch          <= '0;
      r_bias_loaded <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_last    <= 1'b0;
      r_sat_flag    <= 1'b0;
    end else if (bus.bias_load_start) begin
      r_widx        <= '0;
      r_ch          <= '0;
      r_bias_loaded <= 1'b0;
      r_out_valid   <= 1'b0;
      r_sat_flag    <= 1'b0;
    end else begin
      if (w_bias_wr) begin
        r_bias[r_widx] <= bus.bias_in;
        r_widx         <= w_bias_last ? '0 : r_widx + CH_W'(1);
      end
      if (w_bias_last) r_bias_loaded <= 1'b1;

      if (w_acc_take) begin
        r_out_data  <= OUT_W'(w_res);
        r_out_last  <= (r_ch == LAST_CH);
        r_out_valid <= 1'b1;
        r_sat_flag  <= r_sat_flag | w_sat;
        r_ch        <= (r_ch == LAST_CH) ? '0 : r_ch + CH_W'(1);
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.bias_in_ready = (r_state == S_LOAD);
  assign bus.bias_loaded   = r_bias_loaded;
  assign bus.acc_ready     = w_acc_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_data      = r_out_data;
  assign bus.out_last      = r_out_last;
  assign bus.sat_flag      = r_sat_flag;

endmodule

// File: tb/tb_bias_add_stream.sv
// Self-checking bench for bias_add_stream: table vectors, a randomized
// scoreboard stream, load abort and asynchronous reset sequences.
module tb_bias_add_stream;
  localparam int NUM_CH = 64;
  localparam int ACC_W  = 32;
  localparam int BIAS_W = 32;
  localparam int OUT_W  = 16;
  localparam longint MAXV = (longint'(1) << (OUT_W-1)) - 1;
  localparam longint MINV = -(longint'(1) << (OUT_W-1));

  logic clk;
  logic rst;

  bias_add_stream_if #(.ACC_W(ACC_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W)) bus ();

  bias_add_stream #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W))
    dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  longint bmem [NUM_CH];

  typedef struct {
    longint acc;
    bit     relu;
    longint exp_data;
    bit     exp_sat;
  } vec_t;
  vec_t tab [9];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint model(input longint acc, input longint b,
                                   input bit relu, output bit sat);
    longint s;
    s   = acc + b;
    sat = 1'b0;
    if (relu && s < 0) s = 0;
    if (s > MAXV) begin s = MAXV; sat = 1'b1; end
    else if (s < MINV) begin s = MINV; sat = 1'b1; end
    return s;
  endfunction

  task automatic start_load();
    bus.bias_load_start = 1'b1;
    tick();
    bus.bias_load_start = 1'b0;
  endtask

  task automatic load_words();
    for (int i = 0; i < NUM_CH; i++) begin
      bus.bias_in_valid = 1'b1;
      bus.bias_in       = BIAS_W'(bmem[i]);
      if (i == 0) chk("bias_in_ready_load", longint'(bus.bias_in_ready), 1);
      tick();
      if (i == NUM_CH-2) chk("bias_loaded_early", longint'(bus.bias_loaded), 0);
    end
    bus.bias_in_valid = 1'b0;
    chk("bias_loaded_after_last", longint'(bus.bias_loaded), 1);
  endtask

  task automatic one_beat(input string nm, input longint acc, input bit relu,
                          input longint exp_data, input bit exp_last);
    bus.acc_valid = 1'b1;
    bus.acc_in    = ACC_W'(acc);
    bus.relu_en   = relu;
    bus.out_ready = 1'b1;
    tick();
    bus.acc_valid = 1'b0;
    chk({nm, "_valid"}, longint'(bus.out_valid), 1);
    chk({nm, "_data"}, longint'(bus.out_data), exp_data);
    chk({nm, "_last"}, longint'(bus.out_last), longint'(exp_last));
  endtask

  initial begin
    longint q_data[$];
    bit     q_last[$];
    bit     exp_sat;
    bit     s;
    bit     rdy;
    bit     exp_rdy;
    longint a;
    bit     r;
    int     acc_cnt;
    int     out_cnt;
    int     cyc;

    tab[0] = '{1000,    1'b0, 679,    1'b0};
    tab[1] = '{-100,    1'b0, 190,    1'b0};
    tab[2] = '{-5,      1'b1, 0,      1'b0};
    tab[3] = '{-5,      1'b0, -5,     1'b0};
    tab[4] = '{32767,   1'b0, 32767,  1'b0};
    tab[5] = '{-32768,  1'b0, -32768, 1'b0};
    tab[6] = '{40000,   1'b0, 32767,  1'b1};
    tab[7] = '{-40000,  1'b0, -32768, 1'b1};
    tab[8] = '{-1,      1'b1, 0,      1'b1};

    rst = 1'b1;
    bus.bias_load_start = 1'b0;
    bus.bias_in_valid   = 1'b0;
    bus.bias_in         = '0;
    bus.relu_en         = 1'b0;
    bus.acc_valid       = 1'b0;
    bus.acc_in          = '0;
    bus.out_ready       = 1'b0;
    #1;
    chk("rst_bias_in_ready", longint'(bus.bias_in_ready), 0);
    chk("rst_bias_loaded",   longint'(bus.bias_loaded), 0);
    chk("rst_acc_ready",     longint'(bus.acc_ready), 0);
    chk("rst_out_valid",     longint'(bus.out_valid), 0);
    chk("rst_sat_flag",      longint'(bus.sat_flag), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Table vectors on channels 0..8; bias[0]=-321, bias[1]=290, others 0.
    for (int i = 0; i < NUM_CH; i++) bmem[i] = 0;
    bmem[0] = -321;
    bmem[1] = 290;
    start_load();
    load_words();
    for (int i = 0; i < 9; i++) begin
      bus.acc_valid = 1'b1;
      bus.acc_in    = ACC_W'(tab[i].acc);
      bus.relu_en   = tab[i].relu;
      bus.out_ready = 1'b1;
      tick();
      chk($sformatf("tab%0d_valid", i), longint'(bus.out_valid), 1);
      chk($sformatf("tab%0d_data", i),  longint'(bus.out_data), tab[i].exp_data);
      chk($sformatf("tab%0d_sat", i),   longint'(bus.sat_flag), longint'(tab[i].exp_sat));
    end
    bus.acc_valid = 1'b0;
    tick();
    chk("drain_out_valid", longint'(bus.out_valid), 0);

    // Reload clears sat_flag; ReLU on a negative sum is not saturation.
    start_load();
    chk("reload_sat_clear", longint'(bus.sat_flag), 0);
    load_words();
    one_beat("relu_ch0", 0, 1'b1, 0, 1'b0);
    chk("relu_sat", longint'(bus.sat_flag), 0);

    // Randomized stream, 130 beats, out_ready toggling 1,0,1,0...
    for (int i = 0; i < NUM_CH; i++)
      bmem[i] = longint'($urandom_range(0, 2097151)) - 1048576;
    start_load();
    load_words();
    exp_sat = 1'b0;
    rdy     = 1'b1;
    acc_cnt = 0;
    out_cnt = 0;
    cyc     = 0;
    while ((acc_cnt < 130 || q_data.size() != 0) && cyc < 2000) begin
      bus.out_ready = rdy;
      rdy = !rdy;
      if ($urandom_range(0, 1) != 0)
        a = longint'($urandom_range(0, 262143)) - 131072;
      else
        a = longint'($urandom_range(0, 39999)) - 20000;
      r = 1'($urandom_range(0, 1));
      bus.acc_valid = (acc_cnt < 130) && ($urandom_range(0, 3) != 0);
      bus.acc_in    = ACC_W'(a);
      bus.relu_en   = r;
      @(negedge clk);
      exp_rdy = (q_data.size() == 0) || bus.out_ready;
      chk("strm_out_valid", longint'(bus.out_valid), longint'(q_data.size() != 0));
      chk("strm_acc_ready", longint'(bus.acc_ready), longint'(exp_rdy));
      if (q_data.size() != 0 && bus.out_ready) begin
        chk($sformatf("strm_data%0d", out_cnt), longint'(bus.out_data), q_data.pop_front());
        chk($sformatf("strm_last%0d", out_cnt), longint'(bus.out_last), longint'(q_last.pop_front()));
        out_cnt++;
      end
      if (bus.acc_valid && exp_rdy) begin
        q_data.push_back(model(a, bmem[acc_cnt % NUM_CH], r, s));
        q_last.push_back((acc_cnt % NUM_CH) == NUM_CH-1);
        exp_sat = exp_sat | s;
        acc_cnt++;
      end
      tick();
      cyc++;
    end
    bus.acc_valid = 1'b0;
    chk("strm_in_count",  acc_cnt, 130);
    chk("strm_out_count", out_cnt, 130);
    chk("strm_sat_flag",  longint'(bus.sat_flag), longint'(exp_sat));

    // Abort mid-RUN with a stalled output.
    bus.acc_valid = 1'b1;
    bus.acc_in    = ACC_W'(5);
    bus.relu_en   = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    chk("abort_pre_valid", longint'(bus.out_valid), 1);
    bus.bias_load_start = 1'b1;
    tick();
    bus.bias_load_start = 1'b0;
    bus.acc_valid       = 1'b0;
    chk("abort_out_valid",   longint'(bus.out_valid), 0);
    chk("abort_bias_loaded", longint'(bus.bias_loaded), 0);
    chk("abort_acc_ready",   longint'(bus.acc_ready), 0);
    chk("abort_sat_flag",    longint'(bus.sat_flag), 0);
    for (int i = 0; i < NUM_CH; i++) bmem[i] = i * 3 + 7;
    load_words();
    one_beat("abort_ch0", 100, 1'b0, 107, 1'b0);
    one_beat("abort_ch1", 100, 1'b0, 110, 1'b0);

    // Asynchronous reset in the middle of a load (widx = 20).
    tick();
    start_load();
    for (int i = 0; i < 20; i++) begin
      bus.bias_in_valid = 1'b1;
      bus.bias_in       = BIAS_W'(1000 + i);
      tick();
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_bias_in_ready", longint'(bus.bias_in_ready), 0);
    chk("arst_bias_loaded",   longint'(bus.bias_loaded), 0);
    chk("arst_acc_ready",     longint'(bus.acc_ready), 0);
    chk("arst_out_valid",     longint'(bus.out_valid), 0);
    chk("arst_out_data",      longint'(bus.out_data), 0);
    chk("arst_out_last",      longint'(bus.out_last), 0);
    chk("arst_sat_flag",      longint'(bus.sat_flag), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("idle_ignores_bias", longint'(bus.bias_in_ready), 0);
    bus.bias_in_valid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) bmem[i] = -(i + 1);
    start_load();
    load_words();
    one_beat("post_rst_ch0", 50, 1'b0, 49, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
